ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 41 ++++
 rtl/ex_div.sv | 96 +++++++++
 rtl/ex_stage.sv | 94 +++++++++
 tb/tb_ex_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared defines for the execute stage: bus widths, ALU op codes,
// divider FSM state type and small helpers used by the datapath.
package ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 8;

  // ALU operation codes carried in the ID/EX register
  localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
  localparam logic [OP_W-1:0] OP_ADD  = 8'h01;
  localparam logic [OP_W-1:0] OP_SUB  = 8'h02;
  localparam logic [OP_W-1:0] OP_AND  = 8'h03;
  localparam logic [OP_W-1:0] OP_OR   = 8'h04;
  localparam logic [OP_W-1:0] OP_XOR  = 8'h05;
  localparam logic [OP_W-1:0] OP_SLT  = 8'h06;
  localparam logic [OP_W-1:0] OP_SLTU = 8'h07;
  localparam logic [OP_W-1:0] OP_SLL  = 8'h08;
  localparam logic [OP_W-1:0] OP_SRL  = 8'h09;
  localparam logic [OP_W-1:0] OP_SRA  = 8'h0A;
  localparam logic [OP_W-1:0] OP_MUL  = 8'h0B;
  localparam logic [OP_W-1:0] OP_DIV  = 8'h0C;
  localparam logic [OP_W-1:0] OP_DIVU = 8'h0D;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand; only negative values of a signed op are negated
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic signed_op);
    return (signed_op && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for the execute stage: one quotient bit per
// cycle, 32 iterations, sign fix applied on the way out.
// Only compiled when EX_DIVIDER_EN is defined; otherwise ex_stage has no
// divider and this file contributes nothing.
`ifdef EX_DIVIDER_EN
module ex_div
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  div_state_e        state_reg, state_next;
  logic [4:0]        count_reg;
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] divisor_reg;
  logic              negate_reg;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // Trial subtraction: bring the next dividend bit into the partial remainder
  assign shifted = {rem_reg, quo_reg[DATA_W-1]};
  assign diff    = shifted - {1'b0, divisor_reg};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= DIV_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; flush beats everything, including a fresh start
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = DIV_IDLE;
    end else begin
      case (state_reg)
        DIV_IDLE: if (start) state_next = DIV_BUSY;
        DIV_BUSY: if (count_reg == 5'd31) state_next = DIV_DONE;
        DIV_DONE: state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  // Outputs: busy is the stall request, done marks the result cycle
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (!rst && !flush) begin
      case (state_reg)
        DIV_IDLE: busy = start;
        DIV_BUSY: busy = 1'b1;
        DIV_DONE: done = 1'b1;
        default:  ;
      endcase
    end
  end

  // Datapath: latch magnitudes on start, then shift/subtract each BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      negate_reg  <= 1'b0;
    end else if (!flush) begin
      if (state_reg == DIV_IDLE && start) begin
        quo_reg     <= abs_val(a, signed_op);
        divisor_reg <= abs_val(b, signed_op);
        rem_reg     <= '0;
        count_reg   <= '0;
        negate_reg  <= signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
      end else if (state_reg == DIV_BUSY) begin
        count_reg <= count_reg + 5'd1;
        if (!diff[DATA_W]) rem_reg <= diff[DATA_W-1:0];
        else               rem_reg <= shifted[DATA_W-1:0];
        quo_reg <= {quo_reg[DATA_W-2:0], ~diff[DATA_W]};
      end
    end
  end

  assign quotient = negate_reg ? (~quo_reg + 1'b1) : quo_reg;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an optional multi-cycle divider.
// Define EX_DIVIDER_EN to build the divider; without it DIV/DIVU return 0
// and the stage never stalls.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   ex_alu_op,
  input  logic [DATA_W-1:0] ex_alu_src1,
  input  logic [DATA_W-1:0] ex_alu_src2,
  input  logic              ex_regfile_we,
  input  logic [REG_AW-1:0] ex_regfile_waddr,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic              flush,
  output logic              ex_mem_regfile_we,
  output logic [REG_AW-1:0] ex_mem_regfile_waddr,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic              ex_mem_mem_re,
  output logic              ex_mem_mem_we,
  output logic              stall_req
);

  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] div_result;
  logic [4:0]        shamt;
  logic              pass_enables;

  assign shamt = ex_alu_src2[4:0];

  // Single-cycle ALU, results wrap to 32 bits
  always_comb begin
    alu_result = '0;
    case (ex_alu_op)
      OP_ADD:  alu_result = ex_alu_src1 + ex_alu_src2;
      OP_SUB:  alu_result = ex_alu_src1 - ex_alu_src2;
      OP_AND:  alu_result = ex_alu_src1 & ex_alu_src2;
      OP_OR:   alu_result = ex_alu_src1 | ex_alu_src2;
      OP_XOR:  alu_result = ex_alu_src1 ^ ex_alu_src2;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(ex_alu_src1) < $signed(ex_alu_src2)};
      OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, ex_alu_src1 < ex_alu_src2};
      OP_SLL:  alu_result = ex_alu_src1 << shamt;
      OP_SRL:  alu_result = ex_alu_src1 >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(ex_alu_src1) >>> shamt);
      OP_MUL:  alu_result = ex_alu_src1 * ex_alu_src2;
      default: alu_result = '0;
    endcase
  end

`ifdef EX_DIVIDER_EN
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_quotient;

  // Division by zero is answered immediately, so it never starts the FSM
  assign div_start = is_div_op(ex_alu_op) && (ex_alu_src2 != '0);

  ex_div u_ex_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (ex_alu_op == OP_DIV),
    .a         (ex_alu_src1),
    .b         (ex_alu_src2),
    .flush     (flush),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient)
  );

  assign stall_req  = div_busy;
  assign div_result = (ex_alu_src2 == '0) ? '1 :
                      div_done            ? div_quotient : '0;
`else
  // The clock only drives the divider, which is absent in this build
  logic unused_clk;
  assign unused_clk = clk;

  assign stall_req  = 1'b0;
  assign div_result = '0;
`endif

  assign ex_mem_alu_result = is_div_op(ex_alu_op) ? div_result : alu_result;

  // Gated enables: EX/MEM sees a bubble during reset, flush or stall
  assign pass_enables         = !rst && !flush && !stall_req;
  assign ex_mem_regfile_we    = ex_regfile_we && pass_enables;
  assign ex_mem_mem_we        = ex_mem_we && pass_enables;
  assign ex_mem_regfile_waddr = ex_regfile_waddr;
  assign ex_mem_mem_re        = ex_mem_re;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus randomized
// ALU/divide operations compared against an arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [OP_W-1:0]   ex_alu_op;
  logic [DATA_W-1:0] ex_alu_src1;
  logic [DATA_W-1:0] ex_alu_src2;
  logic              ex_regfile_we;
  logic [REG_AW-1:0] ex_regfile_waddr;
  logic              ex_mem_re;
  logic              ex_mem_we;
  logic              flush;
  logic              ex_mem_regfile_we;
  logic [REG_AW-1:0] ex_mem_regfile_waddr;
  logic [DATA_W-1:0] ex_mem_alu_result;
  logic              ex_mem_mem_re;
  logic              ex_mem_mem_we;
  logic              stall_req;

  int tests = 0;
  int fails = 0;

  ex_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_alu_op            (ex_alu_op),
    .ex_alu_src1          (ex_alu_src1),
    .ex_alu_src2          (ex_alu_src2),
    .ex_regfile_we        (ex_regfile_we),
    .ex_regfile_waddr     (ex_regfile_waddr),
    .ex_mem_re            (ex_mem_re),
    .ex_mem_we            (ex_mem_we),
    .flush                (flush),
    .ex_mem_regfile_we    (ex_mem_regfile_we),
    .ex_mem_regfile_waddr (ex_mem_regfile_waddr),
    .ex_mem_alu_result    (ex_mem_alu_result),
    .ex_mem_mem_re        (ex_mem_mem_re),
    .ex_mem_mem_we        (ex_mem_mem_we),
    .stall_req            (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // Reference model straight from the arithmetic definition of each op
  function automatic logic [31:0] ref_result(input logic [7:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] wide;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA: begin
        wide = {{32{a[31]}}, a} >> b[4:0];
        return wide[31:0];
      end
      OP_MUL: begin
        wide = {32'd0, a} * {32'd0, b};
        return wide[31:0];
      end
`ifdef EX_DIVIDER_EN
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $unsigned(sa / sb);
      end
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("%s comparison", tag);
    end
  endtask

  // Present one instruction a little after the edge, then settle before checking
  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic flush_v);
    @(posedge clk);
    #1;
    rst              = 1'b0;
    flush            = flush_v;
    ex_alu_op        = op;
    ex_alu_src1      = a;
    ex_alu_src2      = b;
    ex_regfile_we    = 1'b1;
    ex_mem_we        = 1'b1;
    ex_mem_re        = 1'($urandom_range(0, 1));
    ex_regfile_waddr = 5'($urandom_range(0, 31));
    #1;
  endtask

  task automatic check_single(input string tag, input logic [7:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b, 1'b0);
    check({tag, "_result"}, ex_mem_alu_result, ref_result(op, a, b));
    check({tag, "_stall"}, stall_req, 0);
    check({tag, "_we"}, ex_mem_regfile_we, 1);
    check({tag, "_waddr"}, ex_mem_regfile_waddr, ex_regfile_waddr);
  endtask

`ifdef EX_DIVIDER_EN
  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    int n;
    logic bad;
    drive(op, a, b, 1'b0);
    n = 0;
    bad = 1'b0;
    while (stall_req === 1'b1 && n < 40) begin
      if (ex_mem_regfile_we !== 1'b0 || ex_mem_mem_we !== 1'b0) bad = 1'b1;
      n++;
      @(posedge clk);
      #2;
    end
    check({tag, "_stall_cycles"}, n, 33);
    check({tag, "_bubble_we"}, bad, 0);
    check({tag, "_result"}, ex_mem_alu_result, ref_result(op, a, b));
    check({tag, "_done_we"}, ex_mem_regfile_we, 1);
    check({tag, "_done_mem_we"}, ex_mem_mem_we, 1);
    // Back in IDLE: a following ADD must go straight through
    check_single({tag, "_after"}, OP_ADD, 32'd3, 32'd4);
  endtask
`endif

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [7:0]  op;
    logic [31:0] a, b;

    // Reset with a divide and live enables presented: everything stays quiet
    rst = 1'b1; flush = 1'b0;
    ex_alu_op = OP_DIVU; ex_alu_src1 = 32'd100; ex_alu_src2 = 32'd7;
    ex_regfile_we = 1'b1; ex_mem_we = 1'b1; ex_mem_re = 1'b1; ex_regfile_waddr = 5'd17;
    @(posedge clk); #2;
    check("rst_stall", stall_req, 0);
    check("rst_we", ex_mem_regfile_we, 0);
    check("rst_mem_we", ex_mem_mem_we, 0);
    check("rst_mem_re", ex_mem_mem_re, 1);
    check("rst_waddr", ex_mem_regfile_waddr, 17);
    @(posedge clk); #2;
    check("rst2_stall", stall_req, 0);

    // Overflowing ADD wraps in the same cycle
    check_single("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'd1);
    check("add_wrap_value", ex_mem_alu_result, 32'h8000_0000);

    // Flush gates the enables on a plain ALU op
    drive(OP_SUB, 32'd9, 32'd4, 1'b1);
    check("flush_alu_we", ex_mem_regfile_we, 0);
    check("flush_alu_mem_we", ex_mem_mem_we, 0);
    check("flush_alu_mem_re", ex_mem_mem_re, ex_mem_re);

    // Randomized single-cycle operations
    for (int i = 0; i < 40; i++) begin
      op = 8'($urandom_range(0, 11));
      a = pick_operand();
      b = pick_operand();
      check_single($sformatf("alu%0d_op%0d", i, op), op, a, b);
    end

`ifdef EX_DIVIDER_EN
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    check("divu_100_7_value", ex_mem_alu_result, 32'd7);  // after-ADD 3+4
    run_div("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7);
    run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
      a = $urandom;
      b = (i == 0) ? 32'd1 : ($urandom_range(0, 1) == 0 ? 32'($urandom_range(1, 1000)) : $urandom | 32'd1);
      run_div($sformatf("rdiv%0d", i), op, a, b);
    end

    // Divide by zero: answered immediately, no stall
    check_single("divu_zero", OP_DIVU, 32'd55, 32'd0);
    check("divu_zero_value", ex_mem_alu_result, 32'hFFFF_FFFF);
    check_single("div_zero", OP_DIV, 32'hFFFF_FF00, 32'd0);

    // Flush at count=10 (cycle 11 after arrival)
    drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("flushdiv_start_stall", stall_req, 1);
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    check("flushdiv_stall", stall_req, 0);
    check("flushdiv_we", ex_mem_regfile_we, 0);
    check("flushdiv_mem_we", ex_mem_mem_we, 0);
    check_single("flushdiv_next_add", OP_ADD, 32'd20, 32'd22);

    // Flush in the arrival cycle wins over starting the divide
    drive(OP_DIV, 32'd1000, 32'd3, 1'b1);
    check("flushstart_stall", stall_req, 0);
    check("flushstart_we", ex_mem_regfile_we, 0);
    check_single("flushstart_next", OP_XOR, 32'hF0F0_0000, 32'h0FF0_00FF);

    // Reset at count=5 abandons the division
    drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstdiv_stall", stall_req, 0);
    check("rstdiv_we", ex_mem_regfile_we, 0);
    check("rstdiv_mem_we", ex_mem_mem_we, 0);
    check_single("rstdiv_next_add", OP_ADD, 32'd1, 32'd2);
`else
    // No divider built: divides return 0 without stalling
    check_single("nodiv_divu", OP_DIVU, 32'd100, 32'd7);
    check("nodiv_divu_value", ex_mem_alu_result, 32'd0);
    check_single("nodiv_div_zero", OP_DIV, 32'd5, 32'd0);
    @(posedge clk); #2;
    check("nodiv_hold_stall", stall_req, 0);
    check_single("nodiv_next_add", OP_ADD, 32'd1, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
